// File: rtl/mips_phase_sequencer.sv
// ---------------------------------------------------------------------------
// mips_phase_sequencer
//
// Generates the four non-overlapping phase strobes (pc, inst, data, reg) that
// step a single-cycle MIPS datapath through one instruction. Each phase lasts
// a parameterised number of clock ticks. Cycles run back-to-back while `run`
// is high, or one at a time on a `step` pulse. A non-zero `max_cycles` stops
// the sequencer in DONE once `cycle_count` reaches it. From DONE, only
// `clear` or reset returns the block to IDLE.
//
// Ports
//   clock        in   single clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   run          in   level: run instruction cycles back-to-back
//   step         in   pulse: run exactly one instruction cycle (IDLE only)
//   clear        in   pulse: zero cycle_count, leave DONE (IDLE/DONE only)
//   max_cycles   in   stop limit on cycle_count, 0 = unlimited
//   pc_clock     out  registered strobe, high in PC phase
//   inst_clock   out  registered strobe, high in INST phase
//   data_clock   out  registered strobe, high in DATA phase
//   reg_clock    out  registered strobe, high in REG phase
//   phase        out  0=PC 1=INST 2=DATA 3=REG, 0 when not busy
//   busy         out  high in any phase state
//   done         out  high in DONE
//   cycle_count  out  completed instruction cycles (wraps)
// ---------------------------------------------------------------------------
module mips_phase_sequencer #(
    parameter int unsigned PC_TICKS   = 1,
    parameter int unsigned INST_TICKS = 5,
    parameter int unsigned DATA_TICKS = 5,
    parameter int unsigned REG_TICKS  = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        run,
    input  logic        step,
    input  logic        clear,
    input  logic [31:0] max_cycles,
    output logic        pc_clock,
    output logic        inst_clock,
    output logic        data_clock,
    output logic        reg_clock,
    output logic [1:0]  phase,
    output logic        busy,
    output logic        done,
    output logic [31:0] cycle_count
);

    typedef enum logic [2:0] {
        StIdle,
        StPc,
        StInst,
        StData,
        StReg,
        StDone
    } state_e;

    // Reload values: the counter holds the ticks remaining after the current one.
    localparam logic [7:0] PcLoad   = 8'(PC_TICKS - 1);
    localparam logic [7:0] InstLoad = 8'(INST_TICKS - 1);
    localparam logic [7:0] DataLoad = 8'(DATA_TICKS - 1);
    localparam logic [7:0] RegLoad  = 8'(REG_TICKS - 1);

    state_e      state_q, state_d;
    logic [7:0]  tick_q, tick_d;
    logic [31:0] count_q, count_d;
    logic        pc_q, pc_d;
    logic        inst_q, inst_d;
    logic        data_q, data_d;
    logic        reg_q, reg_d;
    logic [1:0]  phase_q, phase_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        limit_hit;
    logic        inc_hit;
    logic        last_tick;
    logic [31:0] count_inc;

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        count_d   = count_q;
        count_inc = count_q + 32'd1;
        limit_hit = (max_cycles != 32'd0) && (count_q >= max_cycles);
        // The stop decision at the end of REG uses the post-increment count.
        inc_hit   = (max_cycles != 32'd0) && (count_inc >= max_cycles);
        last_tick = (tick_q == 8'd0);

        unique case (state_q)
            StIdle: begin
                if (clear) begin
                    count_d = 32'd0;
                end else if (run || step) begin
                    state_d = limit_hit ? StDone : StPc;
                end
            end
            StPc: begin
                if (last_tick) state_d = StInst;
                else           tick_d  = tick_q - 8'd1;
            end
            StInst: begin
                if (last_tick) state_d = StData;
                else           tick_d  = tick_q - 8'd1;
            end
            StData: begin
                if (last_tick) state_d = StReg;
                else           tick_d  = tick_q - 8'd1;
            end
            StReg: begin
                if (last_tick) begin
                    count_d = count_inc;
                    if (inc_hit)  state_d = StDone;
                    else if (run) state_d = StPc;
                    else          state_d = StIdle;
                end else begin
                    tick_d = tick_q - 8'd1;
                end
            end
            StDone: begin
                if (clear) begin
                    count_d = 32'd0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Every state change reloads the tick counter for the state being entered.
        if (state_d != state_q) begin
            unique case (state_d)
                StPc:    tick_d = PcLoad;
                StInst:  tick_d = InstLoad;
                StData:  tick_d = DataLoad;
                StReg:   tick_d = RegLoad;
                default: tick_d = 8'd0;
            endcase
        end

        // Outputs are decoded from the next state so they are flop outputs
        // that line up exactly with the state register.
        pc_d    = (state_d == StPc);
        inst_d  = (state_d == StInst);
        data_d  = (state_d == StData);
        reg_d   = (state_d == StReg);
        busy_d  = pc_d || inst_d || data_d || reg_d;
        done_d  = (state_d == StDone);
        phase_d = 2'd0;
        if (inst_d) phase_d = 2'd1;
        if (data_d) phase_d = 2'd2;
        if (reg_d)  phase_d = 2'd3;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            tick_q  <= 8'd0;
            count_q <= 32'd0;
            pc_q    <= 1'b0;
            inst_q  <= 1'b0;
            data_q  <= 1'b0;
            reg_q   <= 1'b0;
            phase_q <= 2'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            count_q <= count_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            data_q  <= data_d;
            reg_q   <= reg_d;
            phase_q <= phase_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign pc_clock    = pc_q;
    assign inst_clock  = inst_q;
    assign data_clock  = data_q;
    assign reg_clock   = reg_q;
    assign phase       = phase_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign cycle_count = count_q;

endmodule
